ga_delay_gen: RTL and testbench

GA_DELAY_GEN -- requirements
Module: ga_delay_gen

---
 rtl/ga_delay_gen_if.sv | 12 +
 rtl/ga_delay_gen.sv | 186 ++++++++++++++++++
 tb/tb_ga_delay_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ga_delay_gen_if.sv
// Valid/ready stream bundle used on both sides of the delay generator.
// The master drives data/valid, the slave drives ready.
interface ga_delay_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ga_delay_gen.sv
// ga_delay_gen: inserts a pseudo-random idle gap before every transaction of a
// run. Each gap is drawn from one of RANGES weighted [min,max] delay ranges
// using a 16-bit Fibonacci LFSR. Transactions themselves pass through with no
// added latency.
// Optional feature: define GA_DELAY_STATS_EN to add the HIT_CNT per-range
// selection counters (port hit_cnt).
module ga_delay_gen #(
    parameter int RANGES     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [15:0]                 seed,
    input  logic [CNT_WIDTH-1:0]        trans_count,
    input  logic [RANGES*8-1:0]         range_min,
    input  logic [RANGES*8-1:0]         range_max,
    input  logic [RANGES*8-1:0]         range_weight,
    ga_delay_gen_if.slave               in_bus,
    ga_delay_gen_if.master              out_bus,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_WIDTH-1:0]        sent_cnt
`ifdef GA_DELAY_STATS_EN
    ,
    output logic [RANGES*CNT_WIDTH-1:0] hit_cnt
`endif
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [2:0] {IDLE, SELECT, WAIT, PASS, FIN} state_t;

    state_t                 state_reg, state_next;
    logic [7:0]             cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0]   sent_reg, sent_next;
    logic [15:0]            lfsr_reg, lfsr_next;
    logic [CNT_WIDTH-1:0]   tc_reg;
    logic [RANGES*8-1:0]    min_reg, max_reg, weight_reg;
    logic                   load_cfg;

    logic [15:0]            lfsr_step;
    logic [9:0]             w_sum, w_acc, sel_r;
    logic [7:0]             sel_min, sel_max, span_off, delay_val;
    logic [8:0]             span;
    logic                   found;
    logic [RANGES-1:0]      sel_onehot;

    // Taps 16,14,13,11 feed the new MSB; the register shifts toward bit 0.
    assign lfsr_step = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

    // Weighted range pick from lfsr[7:0], then delay scaled into [min,max] from lfsr[15:8].
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < RANGES; i++) begin
            w_sum = w_sum + 10'(weight_reg[8*i +: 8]);
        end
        sel_r      = 10'((18'(lfsr_reg[7:0]) * 18'(w_sum)) >> 8);
        w_acc      = '0;
        found      = 1'b0;
        sel_min    = min_reg[7:0];
        sel_max    = max_reg[7:0];
        sel_onehot = RANGES'(1);
        for (int i = 0; i < RANGES; i++) begin
            w_acc = w_acc + 10'(weight_reg[8*i +: 8]);
            if (!found && sel_r < w_acc) begin
                found         = 1'b1;
                sel_min       = min_reg[8*i +: 8];
                sel_max       = max_reg[8*i +: 8];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
        span      = {1'b0, sel_max} - {1'b0, sel_min} + 9'd1;
        span_off  = 8'((16'(lfsr_reg[15:8]) * 16'(span)) >> 8);
        delay_val = (sel_max <= sel_min) ? sel_min : sel_min + span_off;
    end

    // Next-state logic and all stream/status outputs.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        sent_next     = sent_reg;
        lfsr_next     = lfsr_reg;
        load_cfg      = 1'b0;
        busy          = (state_reg != IDLE);
        done          = (state_reg == FIN);
        in_bus.ready  = 1'b0;
        out_bus.valid = 1'b0;
        out_bus.data  = {DATA_WIDTH{1'b0}};
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load_cfg   = 1'b1;
                    sent_next  = '0;
                    lfsr_next  = (seed == 16'h0000) ? LFSR_INIT : seed;
                    state_next = (trans_count == '0) ? FIN : SELECT;
                end
            end
            SELECT: begin
                lfsr_next  = lfsr_step;
                cnt_next   = delay_val;
                state_next = (delay_val == 8'd0) ? PASS : WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg <= 8'd1) begin
                    state_next = PASS;
                end
            end
            PASS: begin
                out_bus.valid = in_bus.valid;
                out_bus.data  = in_bus.data;
                in_bus.ready  = out_bus.ready;
                if (in_bus.valid && out_bus.ready) begin
                    sent_next  = sent_reg + CNT_WIDTH'(1);
                    state_next = (sent_next == tc_reg) ? FIN : SELECT;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and LFSR; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sent_reg  <= '0;
            lfsr_reg  <= LFSR_INIT;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sent_reg  <= sent_next;
            lfsr_reg  <= lfsr_next;
        end
    end

    // Run configuration captured when a START is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_reg     <= '0;
            min_reg    <= '0;
            max_reg    <= '0;
            weight_reg <= '0;
        end else if (load_cfg) begin
            tc_reg     <= trans_count;
            min_reg    <= range_min;
            max_reg    <= range_max;
            weight_reg <= range_weight;
        end
    end

    assign sent_cnt = sent_reg;

`ifdef GA_DELAY_STATS_EN
    generate
        for (genvar gi = 0; gi < RANGES; gi++) begin : g_hit
            logic [CNT_WIDTH-1:0] hit_reg;
            // Per-range selection counter; saturates so long runs never wrap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hit_reg <= '0;
                end else if (state_reg == IDLE && start) begin
                    hit_reg <= '0;
                end else if (state_reg == SELECT && sel_onehot[gi] &&
                             hit_reg != {CNT_WIDTH{1'b1}}) begin
                    hit_reg <= hit_reg + CNT_WIDTH'(1);
                end
            end
            assign hit_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = hit_reg;
        end
    endgenerate
`else
    // Selection one-hot only feeds the optional statistics counters.
    logic unused_sel;
    assign unused_sel = ^sel_onehot;
`endif

endmodule

// File: tb/tb_ga_delay_gen.sv
// Randomized bench for ga_delay_gen against a transaction-level gap model.
module tb_ga_delay_gen;
    localparam int RANGES = 4;
    localparam int DW     = 32;
    localparam int CW     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [15:0]          seed;
    logic [CW-1:0]        trans_count;
    logic [RANGES*8-1:0]  range_min, range_max, range_weight;
    logic                 busy, done;
    logic [CW-1:0]        sent_cnt;
`ifdef GA_DELAY_STATS_EN
    logic [RANGES*CW-1:0] hit_cnt;
`endif

    ga_delay_gen_if #(.DATA_WIDTH(DW)) in_bus ();
    ga_delay_gen_if #(.DATA_WIDTH(DW)) out_bus ();

    always #5 clk = ~clk;

    ga_delay_gen #(.RANGES(RANGES), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .trans_count  (trans_count),
        .range_min    (range_min),
        .range_max    (range_max),
        .range_weight (range_weight),
        .in_bus       (in_bus),
        .out_bus      (out_bus),
        .busy         (busy),
        .done         (done),
        .sent_cnt     (sent_cnt)
`ifdef GA_DELAY_STATS_EN
        ,
        .hit_cnt      (hit_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cfg_min[RANGES];
    int cfg_max[RANGES];
    int cfg_wgt[RANGES];
    int hits[RANGES];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11], l[15:1]};
    endfunction

    // Delay (cycles in WAIT) the spec's rules give for one LFSR value.
    function automatic int calc_delay(input logic [15:0] l, output int rng);
        int w, r, acc, mn, mx;
        w = 0;
        for (int i = 0; i < RANGES; i++) w += cfg_wgt[i];
        r   = (int'(l[7:0]) * w) / 256;
        rng = 0;
        acc = 0;
        for (int i = 0; i < RANGES; i++) begin
            acc += cfg_wgt[i];
            if (r < acc) begin
                rng = i;
                break;
            end
        end
        mn = cfg_min[rng];
        mx = cfg_max[rng];
        if (mx <= mn) return mn;
        return mn + (int'(l[15:8]) * (mx - mn + 1)) / 256;
    endfunction

    task automatic drive_cfg();
        for (int i = 0; i < RANGES; i++) begin
            range_min[8*i +: 8]    = 8'(cfg_min[i]);
            range_max[8*i +: 8]    = 8'(cfg_max[i]);
            range_weight[8*i +: 8] = 8'(cfg_wgt[i]);
        end
    endtask

    task automatic set_all(input int mn, input int mx, input int w0, input int w1,
                           input int w2, input int w3);
        for (int i = 0; i < RANGES; i++) begin
            cfg_min[i] = mn;
            cfg_max[i] = mx;
        end
        cfg_wgt[0] = w0; cfg_wgt[1] = w1; cfg_wgt[2] = w2; cfg_wgt[3] = w3;
    endtask

    // One run: pulse START, then check every cycle against the gap model.
    // noise: toggle START/config inputs while busy; stall: random valid/ready;
    // abort_k: assert reset during WAIT of that transaction; rel: release reset with START.
    task automatic run_one(input logic [15:0] s, input int tc, input bit noise,
                           input bit stall, input int abort_k, input bit rel);
        logic [15:0] l;
        int k, cyc, gap, rng, budget;
        bit fin_seen;
        for (int i = 0; i < RANGES; i++) hits[i] = 0;
        @(posedge clk); #1;
        if (rel) rst_n = 1'b1;
        seed          = s;
        trans_count   = 16'(tc);
        drive_cfg();
        start         = 1'b1;
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b0;
        #1;
        check_eq("idle_busy", busy, 1'b0);
        l   = (s == 16'h0000) ? 16'hACE1 : s;
        k   = 0;
        cyc = 0;
        gap = 0;
        if (tc > 0) begin
            gap = 1 + calc_delay(l, rng);
            hits[rng]++;
            l = lfsr_adv(l);
        end
        fin_seen = 1'b0;
        budget   = tc * 600 + 20;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (noise) begin
                seed         = 16'($urandom);
                trans_count  = 16'($urandom_range(0, 7));
                range_weight = $urandom;
            end
            in_bus.valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_bus.ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_bus.data   = $urandom;
            #1;
            if (k == tc) begin
                check_eq("fin_done", done, 1'b1);
                check_eq("fin_busy", busy, 1'b1);
                check_eq("fin_valid", out_bus.valid, 1'b0);
                fin_seen = 1'b1;
                break;
            end
            check_eq("run_busy", busy, 1'b1);
            check_eq("run_done", done, 1'b0);
            check_eq("sent_cnt", sent_cnt, 64'(k));
            if (abort_k == k && cyc >= 1 && cyc < gap) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_status", {busy, done, in_bus.ready, out_bus.valid, sent_cnt}, '0);
                check_eq("abort_data", out_bus.data, '0);
                start = 1'b0;
                $display("run aborted by reset in txn %0d gap cycle %0d", k, cyc);
                return;
            end
            if (cyc < gap) begin
                check_eq("gap_quiet", {out_bus.valid, in_bus.ready, out_bus.data}, '0);
                cyc++;
            end else begin
                check_eq("pass_valid", out_bus.valid, in_bus.valid);
                check_eq("pass_ready", in_bus.ready, out_bus.ready);
                check_eq("pass_data", out_bus.data, in_bus.data);
                if (in_bus.valid && out_bus.ready) begin
                    $display("txn %0d data=0x%08h gap=%0d", k, in_bus.data, gap);
                    k++;
                    cyc = 0;
                    if (k < tc) begin
                        gap = 1 + calc_delay(l, rng);
                        hits[rng]++;
                        l = lfsr_adv(l);
                    end
                end
            end
        end
        if (!fin_seen) begin
            check_eq("timeout", 1'b0, 1'b1);
            start = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check_eq("end_busy", busy, 1'b0);
        check_eq("end_done", done, 1'b0);
        check_eq("end_sent", sent_cnt, 64'(tc));
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        seed          = '0;
        trans_count   = '0;
        range_min     = '0;
        range_max     = '0;
        range_weight  = '0;
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        out_bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_status", {busy, done, in_bus.ready, out_bus.valid, sent_cnt}, '0);
        check_eq("reset_data", out_bus.data, '0);

        // Empty run, START in the very cycle reset is released.
        set_all(1, 4, 1, 1, 1, 1);
        run_one(16'h1234, 0, 1'b0, 1'b0, -1, 1'b1);

        // Fixed delay of 3 through range 0 only.
        set_all(3, 3, 1, 0, 0, 0);
        run_one(16'h5A5A, 5, 1'b0, 1'b0, -1, 1'b0);

        // Single non-zero weight range, long run with back-pressure.
        set_all(2, 9, 0, 7, 0, 0);
        run_one(16'($urandom), 100, 1'b0, 1'b1, -1, 1'b0);
`ifdef GA_DELAY_STATS_EN
        for (int i = 0; i < RANGES; i++) begin
            check_eq("hit_cnt", hit_cnt[CW*i +: CW], 64'(hits[i]));
        end
`endif

        // Reset during the third transaction's wait, then an identical rerun.
        set_all(2, 9, 3, 5, 0, 2);
        run_one(16'hBEEF, 10, 1'b0, 1'b1, 2, 1'b0);
        @(posedge clk); #1;
        check_eq("abort_no_done", {done, busy}, '0);
        run_one(16'hBEEF, 10, 1'b0, 1'b1, -1, 1'b1);

        // Zero seed behaves as 0xACE1; START while busy is ignored.
        set_all(0, 20, 10, 20, 30, 40);
        run_one(16'h0000, 8, 1'b1, 1'b1, -1, 1'b0);
        run_one(16'hACE1, 8, 1'b1, 1'b1, -1, 1'b0);

        // Randomized configurations, including inverted and zero-weight ranges.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < RANGES; i++) begin
                cfg_min[i] = $urandom_range(0, 30);
                cfg_max[i] = $urandom_range(0, 40);
                cfg_wgt[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            end
            if (t == 4) set_all(1, 6, 0, 0, 0, 0);
            run_one(16'($urandom), $urandom_range(1, 15), 1'b1, 1'b1, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
